exec_stage_pipe: RTL
====================

// Module: exec_stage_pipe
// PURPOSE
//  Parametrised execute stage for the EC413 pipeline: operand forwarding, DataSrc operand select,
//  ALU, plus an iterative multi-cycle multiplier. Sits between decode/regfile and memory/writeback.
//  Valid/ready handshake on both sides lets the stage stall upstream during multiplies or output backpressure.
//  Registered result and destination select, same placement as the single-cycle execute stage.
// PARAMETERS
//  DATA_W      32  datapath width; must be a power of 2, >= 8
//  REG_ADDR_W  5   register-select width
//  MUL_BPC     1   multiplier bits retired per cycle; must divide DATA_W
// PORTS
//  Clk             in   1           clock, rising edge
//  Reset           in   1           asynchronous, active-high reset
//  in_valid        in   1           upstream presents an op
//  in_ready        out  1           stage accepts op this cycle
//  Rs1Select       in   REG_ADDR_W  source reg of ReadData_1 (for forwarding)
//  Rs2Select       in   REG_ADDR_W  source reg of ReadData_2 (for forwarding)
//  ReadData_1      in   DATA_W      operand A from regfile
//  ReadData_2      in   DATA_W      operand B from regfile
//  Imm             in   DATA_W      sign-extended immediate
//  DataSrc         in   1           0: B = fwd(ReadData_2); 1: B = Imm
//  ALUOp           in   4           operation code (see BEHAVIOUR)
//  WriteSelect_in  in   REG_ADDR_W  destination register
//  wb_valid        in   1           writeback stage writing this cycle
//  wb_sel          in   REG_ADDR_W  writeback destination
//  wb_data         in   DATA_W      writeback value
//  out_valid       out  1           ALUOut/WriteSelect_out hold a result
//  out_ready       in   1           downstream consumes result
//  ALUOut          out  DATA_W      registered result
//  WriteSelect_out out  REG_ADDR_W  registered destination
//  Zero            out  1           registered (ALUOut == 0)
//  Ovf             out  1           registered signed overflow (ADD/SUB only, else 0)
// BEHAVIOUR
//  - Reset (async): out_valid=0, ALUOut=0, WriteSelect_out=0, Zero=0, Ovf=0, FSM=IDLE, counter=0.
//    Reset mid-multiply aborts it; no result is produced.
//  - Accept = in_valid & in_ready. in_ready = (state==IDLE) & (~out_valid | out_ready).
//  - Forwarding (per source, reg 0 never forwarded): priority 1 = own output reg when out_valid &
//    WriteSelect_out==RsX; priority 2 = wb when wb_valid & wb_sel==RsX; else ReadData_X.
//  - ALUOp: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 0/1), 6 SLL, 7 SRL, 8 SRA,
//    9 MUL (low DATA_W bits of product); 10-15 -> result 0, single-cycle.
//  - Shifts use B[$clog2(DATA_W)-1:0]; upper bits ignored. Arithmetic wraps modulo 2^DATA_W.
//  - Single-cycle ops: result registered on the accept edge; out_valid=1 next cycle (latency 1).
//  - MUL: FSM IDLE -> MUL on accept (operands, dest latched); MUL_BPC bits per cycle for
//    DATA_W/MUL_BPC cycles; on final MUL cycle result loads output regs, out_valid=1, FSM -> IDLE.
//    Latency DATA_W/MUL_BPC cycles; in_ready=0 throughout MUL.
//  - Output hold: out_valid & ~out_ready freezes all outputs; in_ready=0. out_valid & out_ready
//    with no new accept -> out_valid=0 next cycle; with accept -> new result replaces (back-to-back).
//  - Forwarding from own output reg is valid whether or not it is consumed that cycle.
// STRUCTURE
//  - Package exec_pkg: ALUOp localparams (OP_ADD..OP_MUL), FSM state encodings (ST_IDLE, ST_MUL).
//  - Sub-module exec_mul_iter: shift-add multiplier (start, busy, done, product), MUL_BPC param.
//  - ALU, forwarding muxes, operand-select mux, handshake and output regs stay in this module.
// TESTING
//  - Reset then ADD A=5 B=7 DataSrc=0 -> 1 cycle later ALUOut=12, out_valid=1, Zero=0, Ovf=0.
//  - SUB 0x7FFFFFFF - 0xFFFFFFFF -> ALUOut=0x80000000, Ovf=1; SUB 3-3 -> Zero=1.
//  - Back-to-back ADD r3=1+2 then ADD r4=r3+Imm 10 (stale ReadData_1=0) -> ALUOut=13 via EX fwd;
//    with wb_valid wb_sel=3 wb_data=99 simultaneously -> EX fwd wins, still 13.
//  - MUL 6*7, DATA_W=32, MUL_BPC=1 -> in_ready=0 for 32 cycles, then ALUOut=42; MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE.
//  - out_ready held 0 for 5 cycles after a result -> outputs stable, in_ready=0; release -> next op accepted.
//  - Assert Reset 10 cycles into MUL -> out_valid=0, FSM IDLE, in_ready=1 after release; SRA 0x80000000 by 33 -> 0xC0000000.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU opcodes and control FSM states.
package exec_pkg;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;
endpackage

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_BPC multiplier bits per cycle.
// product is combinational and valid in the cycle done is high (low DATA_W bits).
module exec_mul_iter
    import exec_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUL_BPC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);
    localparam int STEPS = DATA_W / MUL_BPC;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    logic [DATA_W-1:0] mcand, mplier, acc, partial, acc_next;
    logic [CNT_W-1:0]  cnt;

    // Multiplicand is pre-shifted each step, so the partial product needs no offset.
    assign partial  = mcand * DATA_W'(mplier[MUL_BPC-1:0]);
    assign acc_next = acc + partial;
    assign done     = busy && (cnt == CNT_W'(STEPS - 1));
    assign product  = acc_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << MUL_BPC;
            mplier <= mplier >> MUL_BPC;
            cnt    <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/exec_stage_pipe.sv
// Execute stage: operand forwarding, operand select, ALU and iterative multiply
// behind a valid/ready handshake with a registered result.
module exec_stage_pipe
    import exec_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MUL_BPC    = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] Rs1Select,
    input  logic [REG_ADDR_W-1:0] Rs2Select,
    input  logic [DATA_W-1:0]     ReadData_1,
    input  logic [DATA_W-1:0]     ReadData_2,
    input  logic [DATA_W-1:0]     Imm,
    input  logic                  DataSrc,
    input  logic [3:0]            ALUOp,
    input  logic [REG_ADDR_W-1:0] WriteSelect_in,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_sel,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     ALUOut,
    output logic [REG_ADDR_W-1:0] WriteSelect_out,
    output logic                  Zero,
    output logic                  Ovf
);
    localparam int SH_W = $clog2(DATA_W);

    state_t                state, state_next;
    logic                  accept, mul_start, mul_busy, mul_done;
    logic [DATA_W-1:0]     fwd_1, fwd_2, op_a, op_b, res, mul_product;
    logic                  ovf;
    logic [SH_W-1:0]       shamt;
    logic [REG_ADDR_W-1:0] mul_dest;

    assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (ALUOp == OP_MUL);

    // Own output register outranks writeback: it holds the younger value.
    always_comb begin
        fwd_1 = ReadData_1;
        fwd_2 = ReadData_2;
        if (Rs1Select != '0 && out_valid && WriteSelect_out == Rs1Select) fwd_1 = ALUOut;
        else if (Rs1Select != '0 && wb_valid && wb_sel == Rs1Select)      fwd_1 = wb_data;
        if (Rs2Select != '0 && out_valid && WriteSelect_out == Rs2Select) fwd_2 = ALUOut;
        else if (Rs2Select != '0 && wb_valid && wb_sel == Rs2Select)      fwd_2 = wb_data;
    end

    assign op_a  = fwd_1;
    assign op_b  = DataSrc ? Imm : fwd_2;
    assign shamt = op_b[SH_W-1:0];

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (ALUOp)
            OP_ADD: begin
                res = op_a + op_b;
                ovf = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (res[DATA_W-1] != op_a[DATA_W-1]);
            end
            OP_SUB: begin
                res = op_a - op_b;
                ovf = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (res[DATA_W-1] != op_a[DATA_W-1]);
            end
            OP_AND: res = op_a & op_b;
            OP_OR:  res = op_a | op_b;
            OP_XOR: res = op_a ^ op_b;
            OP_SLT: res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLL: res = op_a << shamt;
            OP_SRL: res = op_a >> shamt;
            OP_SRA: res = $signed(op_a) >>> shamt;
            default: res = '0;
        endcase
    end

    exec_mul_iter #(.DATA_W(DATA_W), .MUL_BPC(MUL_BPC)) u_mul (
        .clk     (Clk),
        .rst     (Reset),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (mul_start)             state_next = ST_MUL;
            ST_MUL:  if (mul_done || !mul_busy) state_next = ST_IDLE;
            default:                            state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_valid       <= 1'b0;
            ALUOut          <= '0;
            WriteSelect_out <= '0;
            Zero            <= 1'b0;
            Ovf             <= 1'b0;
            mul_dest        <= '0;
        end else begin
            if (mul_start) mul_dest <= WriteSelect_in;
            if (accept && ALUOp != OP_MUL) begin
                out_valid       <= 1'b1;
                ALUOut          <= res;
                WriteSelect_out <= WriteSelect_in;
                Zero            <= (res == '0);
                Ovf             <= ovf;
            end else if (mul_done) begin
                out_valid       <= 1'b1;
                ALUOut          <= mul_product;
                WriteSelect_out <= mul_dest;
                Zero            <= (mul_product == '0);
                Ovf             <= 1'b0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
